// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serialiser driven by baud_clk rising-edge ticks
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);

  state_t               state_q, state_d;
  logic                 baud_q;
  logic                 tick;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  // baud_clk is already sampled by baud_q, so a rising edge is a one-cycle tick
  assign tick = baud_clk & ~baud_q;

  // Next-state, datapath and next line level; tx_d follows the state being entered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD;
          state_d  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (tick) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q < LAST_BIT) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = HAS_PAR ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q < LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_clk;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed frame-level bench for uart_tx across parameter sets
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clk = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [4:0] d3 = '0;
  logic [3:0] valid_v = '0;
  logic [3:0] ready_v, tx_v, busy_v, done_v;
  int         half = 434;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int         d;
    int         hb;
    logic [7:0] data;
    int         nbits;
    logic [15:0] seq;
    string      nm;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  // baud_clk square wave, period 2*half clk cycles, edges placed on falling clk
  initial begin
    forever begin
      repeat (half) @(negedge clk);
      baud_clk = ~baud_clk;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // default: 8N1
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d0), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  // 8E2
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d1), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  // 8O1
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d2), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  // 5N1
  uart_tx #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d3), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_word(input int d, input logic [7:0] w);
    case (d)
      0: d0 = w;
      1: d1 = w;
      2: d2 = w;
      default: d3 = w[4:0];
    endcase
  endtask

  // Present a word, wait (bounded) for ready, let the accept edge pass, drop valid
  task automatic accept(input int d, input logic [7:0] w, input string nm);
    int n;
    n = 0;
    set_word(d, w);
    valid_v[d] = 1'b1;
    while (ready_v[d] !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    chk({nm, " ready"}, 32'(ready_v[d]), 32'd1);
    step();
    valid_v[d] = 1'b0;
  endtask

  // Find the start bit, then check every bit level at its first and last cycle,
  // the tx_done pulse position and its one-cycle width
  task automatic check_frame(input int d, input int nbits, input logic [15:0] seq,
                             input string nm, output int s);
    int   n;
    int   p;
    logic first, last, dn;
    n = 0;
    p = 2 * half;
    while (tx_v[d] !== 1'b0 && n < 4 * p + 2000) begin
      step();
      n++;
    end
    chk({nm, " start"}, 32'(tx_v[d]), 32'd0);
    s = cyc;
    chk({nm, " busy"}, 32'(busy_v[d]), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      first = tx_v[d];
      repeat (p - 1) step();
      last = tx_v[d];
      dn   = done_v[d];
      chk($sformatf("%s bit%0d", nm, k), 32'({first, last, dn}), 32'({seq[k], seq[k], 1'b0}));
      step();
    end
    chk({nm, " done/ready/tx"}, 32'({done_v[d], ready_v[d], tx_v[d]}), 32'b111);
    step();
    chk({nm, " done pulse"}, 32'(done_v[d]), 32'd0);
  endtask

  initial begin
    int s1, s2, n;

    // sequences written bit0 = start bit, LSB-first data, parity, stops
    vecs[0] = '{0, 434, 8'h55, 10, 16'h02AA, "u0_55"};
    vecs[1] = '{0, 8,   8'hA3, 10, 16'h0346, "u0_A3"};
    vecs[2] = '{0, 8,   8'h00, 10, 16'h0200, "u0_00"};
    vecs[3] = '{0, 8,   8'hFF, 10, 16'h03FE, "u0_FF"};
    vecs[4] = '{1, 8,   8'h07, 12, 16'h0E0E, "u1_07"};
    vecs[5] = '{1, 8,   8'h03, 12, 16'h0C06, "u1_03"};
    vecs[6] = '{2, 8,   8'h07, 11, 16'h040E, "u2_07"};
    vecs[7] = '{2, 8,   8'h00, 11, 16'h0600, "u2_00"};
    vecs[8] = '{3, 8,   8'h1F, 7,  16'h007E, "u3_1F"};
    vecs[9] = '{3, 8,   8'h0A, 7,  16'h0054, "u3_0A"};

    #23;
    chk("reset state", 32'({tx_v, ready_v, busy_v, done_v}), 32'h0000FF00);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      half = vecs[i].hb;
      accept(vecs[i].d, vecs[i].data, vecs[i].nm);
      check_frame(vecs[i].d, vecs[i].nbits, vecs[i].seq, vecs[i].nm, s1);
    end

    // reset in the middle of the data bits (0xA3 bit2 is a 0)
    accept(0, 8'hA3, "rst");
    n = 0;
    while (tx_v[0] !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    repeat (3 * 2 * half + half) step();
    chk("rst pre tx", 32'(tx_v[0]), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst async", 32'({tx_v[0], ready_v[0], busy_v[0], done_v[0]}), 32'b1100);
    reset = 1'b0;
    step();
    accept(0, 8'hA3, "post_rst");
    check_frame(0, 10, 16'h0346, "post_rst", s1);

    // handshake: second word held valid during the first frame
    accept(0, 8'h0F, "hs1");
    set_word(0, 8'hF0);
    valid_v[0] = 1'b1;
    check_frame(0, 10, 16'h021E, "hs1", s1);
    valid_v[0] = 1'b0;
    chk("hs accepted", 32'(ready_v[0]), 32'd0);
    check_frame(0, 10, 16'h03E0, "hs2", s2);
    chk("hs gap", 32'(s2 - s1), 32'(11 * 2 * half));

    // accept in the same cycle as a tick
    step();
    @(posedge baud_clk);
    set_word(0, 8'h3C);
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    repeat (2 * half - 1) step();
    chk("coinc before", 32'(tx_v[0]), 32'd1);
    step();
    chk("coinc start", 32'(tx_v[0]), 32'd0);
    check_frame(0, 10, 16'h0278, "coinc", s1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
